aes128_iter_ctrl: RTL
=====================

Name: aes128_iter_ctrl

Overview:
Iterative AES-128 encryption engine controller. It sequences the shared round primitives SubBytes, ShiftRows, MixColumns and AddRoundKey, one round per clock. Round keys are expanded on the fly. It accepts a plaintext/key pair over a valid/ready handshake and returns the ciphertext over a second valid/ready handshake. It sits between the host-facing block buffer and the downstream ciphertext FIFO.

Parameters:
NR, 10, number of cipher rounds; only 10 (AES-128) is supported, other values are illegal.
RCON_INIT, 8'h01, first round constant; fixed by FIPS-197, exposed for bench visibility only.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  plaintext/key offered
in_ready  out  1  block can accept a new job
in_data  in  128  plaintext; byte k at [8k+7:8k], column-major (byte = row + 4*col)
in_key  in  128  cipher key, same byte ordering
out_valid  out  1  ciphertext available
out_ready  in  1  downstream accepts ciphertext
out_data  out  128  ciphertext, same byte ordering
busy  out  1  rounds in progress
round_idx  out  4  current round number, debug

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). On rst: FSM=IDLE, in_ready=1, out_valid=0, busy=0, round_idx=0, out_data=0, state/key registers=0. Reset mid-round aborts the job with no output.
- FSM states: IDLE, ROUND, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready (accept edge E0):
  - state_reg <= in_data ^ in_key (round 0 AddRoundKey)
  - key_reg <= in_key, rcon <= 8'h01, round_idx <= 1
  - go to ROUND.
- ROUND: busy=1, in_ready=0. Each edge:
  - key' = KeyStep(key_reg, rcon)
  - state_reg <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state_reg))), key')
  - key_reg <= key', rcon <= xtime(rcon), round_idx++
  - When round_idx==NR, MixColumns is bypassed, out_data <= result, out_valid <= 1, go to DONE.
- Latency: out_valid first high in the cycle after edge E10, i.e. 10 clocks after the accept edge. Throughput: 1 block per 12 clocks minimum.
- DONE: out_valid=1, busy=0, out_data stable. On out_valid&&out_ready: out_valid <= 0, round_idx <= 0, go to IDLE. in_ready rises the next cycle; there is no same-cycle accept from DONE. out_ready low stalls indefinitely with no data change.
- in_valid, in_data and in_key are ignored outside IDLE and sampled only at the accept edge.
- KeyStep: words w_j = key[32j+31:32j].
  - t = SubWord(RotWord(w3)) with rcon XORed into byte 0 of t.
  - RotWord(a0,a1,a2,a3) = (a1,a2,a3,a0).
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
- rcon sequence: 01,02,04,08,10,20,40,80,1b,36. xtime uses GF(2^8) reduction by 0x1b; the rollover 0x80 -> 0x1b must be correct.
- All round arithmetic is exact GF(2^8) per FIPS-197. Integer multiplication is forbidden in the datapath.

Decomposition:
- Shared aes package/header holds:
  - FSM state encodings
  - NR
  - the 10-entry RCON table, or xtime as a function
  - the byte-index macro (row + 4*col)
- One sub-module: aes_key_step, combinational. It takes a 128-bit key and 8-bit rcon and produces the next 128-bit key, using 4 SBox instances.
- The controller instantiates one each of the shared SubBytes, ShiftRows, MixColumns and AddRoundKey, plus a 128-bit 2:1 mux for the final-round MixColumns bypass.

Test Plan:
1. FIPS-197 C.1: key 000102..0f, pt 00112233445566778899aabbccddeeff (byte 0 at [7:0]) -> ct 69c4e0d86a7b0430d8cdb78070b4c55a. out_valid rises exactly 10 clocks after accept; internal key_reg after round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
2. FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32. round_idx steps 1..10.
3. Back-to-back C.1 then B with in_valid held high and out_ready=1 -> two correct ciphertexts, 12-clock spacing. The second block is accepted only after out handshake plus 1 cycle.
4. out_ready held low 5 cycles after out_valid -> out_valid and out_data stable for those 5 cycles. After out_ready=1, IDLE and in_ready=1 one cycle later.
5. in_valid pulsed with garbage data/key at round 4 -> ignored, in_ready=0, ciphertext still correct.
6. rst asserted at round 5 for one cycle -> next cycle IDLE, out_valid=0, busy=0, round_idx=0. A fresh C.1 job then completes correctly.

Source files
------------

// File: rtl/aes128_iter_ctrl_pkg.sv
// Shared AES-128 definitions: FSM states, round count, S-box table and the
// byte-level round primitives used by the iterative controller.
package aes128_iter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int          AES_NR        = 10;
  localparam logic [7:0]  AES_RCON_INIT = 8'h01;

  // S-box packed MSB-first: entry b lives at bits [{~b,3'b111} -: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte k of a 128-bit block sits at row k%4, column k/4.
  function automatic int byte_idx(input int row, input int col);
    return (col << 2) + row;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) o[(k << 3) +: 8] = sbox(s[(k << 3) +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[(byte_idx(r, c) << 3) +: 8] = s[(byte_idx(r, (c + r) & 3) << 3) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[(byte_idx(0, c) << 3) +: 8];
      a1 = s[(byte_idx(1, c) << 3) +: 8];
      a2 = s[(byte_idx(2, c) << 3) +: 8];
      a3 = s[(byte_idx(3, c) << 3) +: 8];
      o[(byte_idx(0, c) << 3) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[(byte_idx(1, c) << 3) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[(byte_idx(2, c) << 3) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[(byte_idx(3, c) << 3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction

endpackage

// File: rtl/aes128_iter_ctrl_key_step.sv
// Combinational on-the-fly AES-128 key expansion: derives the next round key
// from the current one and the round constant.
module aes128_iter_ctrl_key_step
  import aes128_iter_ctrl_pkg::*;
(
  input  logic [127:0] key,
  input  logic [7:0]   rcon,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3, rot, t;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key[31:0];
  assign w1 = key[63:32];
  assign w2 = key[95:64];
  assign w3 = key[127:96];

  // Byte 0 is the low byte, so rotating left by one byte moves a1 into slot 0.
  assign rot = {w3[7:0], w3[31:8]};
  assign t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0]) ^ rcon};

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n3, n2, n1, n0};

endmodule

// File: rtl/aes128_iter_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock with the round
// key expanded alongside, valid/ready handshakes on both sides.
module aes128_iter_ctrl
  import aes128_iter_ctrl_pkg::*;
#(
  parameter int         NR        = AES_NR,
  parameter logic [7:0] RCON_INIT = AES_RCON_INIT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [3:0]   round_idx
);

  state_t       fsm;
  logic [127:0] state_reg, key_reg, next_key;
  logic [127:0] sr_out, mc_out, mix_sel, round_out;
  logic [7:0]   rcon;

  aes128_iter_ctrl_key_step u_key_step (
    .key      (key_reg),
    .rcon     (rcon),
    .next_key (next_key)
  );

  // The last round skips MixColumns, so the mux picks the ShiftRows result.
  assign sr_out    = shift_rows(sub_bytes(state_reg));
  assign mc_out    = mix_columns(sr_out);
  assign mix_sel   = (round_idx == 4'(NR)) ? sr_out : mc_out;
  assign round_out = add_round_key(mix_sel, next_key);

  // Control and datapath registers. round_idx holds at NR while the result waits
  // in DONE and clears only once the ciphertext has been taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      round_idx <= 4'd0;
      out_data  <= '0;
      state_reg <= '0;
      key_reg   <= '0;
      rcon      <= 8'h00;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid && in_ready) begin
            state_reg <= add_round_key(in_data, in_key);
            key_reg   <= in_key;
            rcon      <= RCON_INIT;
            round_idx <= 4'd1;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            fsm       <= ROUND;
          end
        end
        ROUND: begin
          state_reg <= round_out;
          key_reg   <= next_key;
          rcon      <= xtime(rcon);
          if (round_idx == 4'(NR)) begin
            out_data  <= round_out;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            fsm       <= DONE;
          end else begin
            round_idx <= round_idx + 4'd1;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            round_idx <= 4'd0;
            in_ready  <= 1'b1;
            fsm       <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
